// File: rtl/if_stage.sv
// +----------------------------------------------------------------------------+
// | if_stage : instruction fetch with a DEPTH-entry buffer, stall, redirect,    |
// |            halt-on-HLT. Optional IF_PERF_CNT_EN adds fetch/bubble counters.|
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module if_stage #(
  parameter int          DEPTH      = 2,
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [3:0]  HLT_OPCODE = 4'hF,
  parameter logic [15:0] NOP_INSTR  = 16'h0000
) (
  input  logic        i_clk,
  input  logic        i_nRst,
  output logic        o_imemReq,
  output logic [15:0] o_imemAddr,
  input  logic        i_imemAck,
  input  logic [15:0] i_imemData,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [15:0] i_target,
  output logic [15:0] o_instr,
  output logic [15:0] o_pc,
  output logic        o_valid,
  output logic        o_halted
`ifdef IF_PERF_CNT_EN
  ,
  output logic [15:0] o_fetchCnt,
  output logic [15:0] o_bubbleCnt
`endif
);

  localparam int            AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int            CW      = AW + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [15:0]   fpc_q, fpc_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [15:0]   last_pc_q;
  logic [15:0]   instr_mem_q [DEPTH];
  logic [15:0]   pc_mem_q    [DEPTH];
  logic          w_xfer;
  logic          w_pop;

  // Request uses the registered count only, so a full buffer never refetches on a pop.
  assign o_imemReq  = i_nRst && (state_q == ST_RUN) && (count_q < C_DEPTH) && !i_redirect;
  assign o_imemAddr = fpc_q;
  assign w_xfer     = o_imemReq && i_imemAck;
  assign o_valid    = (count_q != '0);
  assign w_pop      = o_valid && !i_stall;
  assign o_instr    = o_valid ? instr_mem_q[rd_ptr_q] : NOP_INSTR;
  assign o_pc       = o_valid ? pc_mem_q[rd_ptr_q] : last_pc_q;
  assign o_halted   = (state_q == ST_HALTED);

  always_comb begin
    state_d  = state_q;
    fpc_d    = fpc_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (i_redirect) begin
      state_d  = ST_RUN;
      fpc_d    = i_target;
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (w_xfer) begin
        fpc_d    = fpc_q + 16'd1;
        wr_ptr_d = wr_ptr_q + AW'(1);
        if (i_imemData[15:12] == HLT_OPCODE) begin
          state_d = ST_HALTED;
        end
      end
      if (w_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(w_xfer) - CW'(w_pop);
    end
  end

  always_ff @(posedge i_clk or negedge i_nRst) begin
    if (!i_nRst) begin
      state_q   <= ST_RUN;
      fpc_q     <= RESET_PC;
      count_q   <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      last_pc_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      fpc_q     <= fpc_d;
      count_q   <= count_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      last_pc_q <= o_pc;
    end
  end

  // Buffer payload needs no reset; o_valid masks stale slots.
  always_ff @(posedge i_clk) begin
    if (w_xfer) begin
      instr_mem_q[wr_ptr_q] <= i_imemData;
      pc_mem_q[wr_ptr_q]    <= fpc_q + 16'd1;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [15:0] fetch_cnt_q;
  logic [15:0] bubble_cnt_q;

  always_ff @(posedge i_clk or negedge i_nRst) begin
    if (!i_nRst) begin
      fetch_cnt_q  <= 16'h0000;
      bubble_cnt_q <= 16'h0000;
    end else begin
      if (w_xfer) begin
        fetch_cnt_q <= fetch_cnt_q + 16'd1;
      end
      if (!o_valid && (state_q == ST_RUN)) begin
        bubble_cnt_q <= bubble_cnt_q + 16'd1;
      end
    end
  end

  assign o_fetchCnt  = fetch_cnt_q;
  assign o_bubbleCnt = bubble_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// +----------------------------------------------------------------------------+
// | tb_if_stage : randomized bench for if_stage against a queue-based model.    |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_if_stage;

  localparam int          DEPTH = 2;
  localparam logic [15:0] NOP   = 16'h0000;

  logic        i_clk = 1'b0;
  logic        i_nRst = 1'b0;
  logic        o_imemReq;
  logic [15:0] o_imemAddr;
  logic        i_imemAck = 1'b0;
  logic [15:0] i_imemData = 16'h0000;
  logic        i_stall = 1'b0;
  logic        i_redirect = 1'b0;
  logic [15:0] i_target = 16'h0000;
  logic [15:0] o_instr;
  logic [15:0] o_pc;
  logic        o_valid;
  logic        o_halted;

  if_stage #(
    .DEPTH(DEPTH), .RESET_PC(16'h0000), .HLT_OPCODE(4'hF), .NOP_INSTR(NOP)
  ) dut (
    .i_clk(i_clk), .i_nRst(i_nRst),
    .o_imemReq(o_imemReq), .o_imemAddr(o_imemAddr),
    .i_imemAck(i_imemAck), .i_imemData(i_imemData),
    .i_stall(i_stall), .i_redirect(i_redirect), .i_target(i_target),
    .o_instr(o_instr), .o_pc(o_pc), .o_valid(o_valid), .o_halted(o_halted)
  );

  always #5 i_clk = ~i_clk;

  int          n_checks = 0;
  int          n_err    = 0;
  int          cyc      = 0;
  logic [15:0] q_instr[$];
  logic [15:0] q_pc[$];
  logic [15:0] m_fpc;
  logic [15:0] m_last_pc;
  bit          m_halt;
  bit          hlt_en = 1'b0;
  logic [15:0] hlt_addr = 16'h0000;
  logic        e_valid, e_req, e_halted;
  logic [15:0] e_instr, e_pc, e_addr;

  // Memory image: addr+0x1000 everywhere, optionally an HLT word at one address.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (hlt_en && a == hlt_addr) return 16'hF000;
    return a + 16'h1000;
  endfunction

  task automatic model_reset();
    q_instr.delete();
    q_pc.delete();
    m_fpc     = 16'h0000;
    m_last_pc = 16'h0000;
    m_halt    = 1'b0;
  endtask

  // Drive one cycle's inputs and derive the expected outputs from the model.
  task automatic apply(input bit st, input bit rd, input logic [15:0] tg, input bit ack);
    i_stall    = st;
    i_redirect = rd;
    i_target   = tg;
    i_imemAck  = ack;
    i_imemData = mem_word(m_fpc);
    #1;
    e_valid  = (q_instr.size() != 0);
    e_instr  = e_valid ? q_instr[0] : NOP;
    e_pc     = e_valid ? q_pc[0] : m_last_pc;
    e_req    = !m_halt && (q_instr.size() < DEPTH) && !rd;
    e_addr   = m_fpc;
    e_halted = m_halt;
  endtask

  // Advance the model across the clock edge, then move to the next falling edge.
  task automatic tick();
    logic [15:0] nxt;
    m_last_pc = e_pc;
    if (i_redirect) begin
      q_instr.delete();
      q_pc.delete();
      m_fpc  = i_target;
      m_halt = 1'b0;
    end else begin
      if (e_valid && !i_stall) begin
        void'(q_instr.pop_front());
        void'(q_pc.pop_front());
      end
      if (e_req && i_imemAck) begin
        nxt = m_fpc + 16'd1;
        q_instr.push_back(i_imemData);
        q_pc.push_back(nxt);
        if (i_imemData[15:12] == 4'hF) m_halt = 1'b1;
        m_fpc = nxt;
      end
    end
    @(posedge i_clk);
    @(negedge i_clk);
    cyc++;
  endtask

  task automatic test_reset();
    #1;
    if ({o_valid, o_instr, o_pc, o_imemReq, o_halted} !== {1'b0, NOP, 16'h0000, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_t0: got v=%b i=%h pc=%h req=%b h=%b, exp 0 %h 0000 0 0",
               o_valid, o_instr, o_pc, o_imemReq, o_halted, NOP);
    end
    n_checks++;
    @(posedge i_clk);
    #1;
    if ({o_valid, o_instr, o_pc, o_imemReq, o_halted, o_imemAddr} !== {1'b0, NOP, 16'h0000, 1'b0, 1'b0, 16'h0000}) begin
      n_err++;
      $display("FAIL reset_edge: got v=%b i=%h pc=%h req=%b h=%b a=%h, exp 0 %h 0000 0 0 0000",
               o_valid, o_instr, o_pc, o_imemReq, o_halted, o_imemAddr, NOP);
    end
    n_checks++;
    @(negedge i_clk);
    i_nRst = 1'b1;
    model_reset();
  endtask

  task automatic test_stream();
    for (int k = 0; k < 8; k++) begin
      apply(1'b0, 1'b0, 16'h0000, 1'b1);
      if ({o_valid, o_instr, o_pc, o_imemReq, o_imemAddr, o_halted} !== {e_valid, e_instr, e_pc, e_req, e_addr, e_halted}) begin
        n_err++;
        $display("FAIL stream cyc %0d: got v=%b i=%h pc=%h req=%b a=%h h=%b, exp v=%b i=%h pc=%h req=%b a=%h h=%b", cyc,
                 o_valid, o_instr, o_pc, o_imemReq, o_imemAddr, o_halted, e_valid, e_instr, e_pc, e_req, e_addr, e_halted);
      end
      n_checks++;
      tick();
    end
  endtask

  task automatic test_stall();
    for (int k = 0; k < 13; k++) begin
      if (k == 0) apply(1'b0, 1'b1, 16'h0000, 1'b1);
      else        apply((k >= 1 && k <= 5), 1'b0, 16'h0000, 1'b1);
      if ({o_valid, o_instr, o_pc, o_imemReq, o_imemAddr, o_halted} !== {e_valid, e_instr, e_pc, e_req, e_addr, e_halted}) begin
        n_err++;
        $display("FAIL stall cyc %0d: got v=%b i=%h pc=%h req=%b a=%h h=%b, exp v=%b i=%h pc=%h req=%b a=%h h=%b", cyc,
                 o_valid, o_instr, o_pc, o_imemReq, o_imemAddr, o_halted, e_valid, e_instr, e_pc, e_req, e_addr, e_halted);
      end
      n_checks++;
      tick();
    end
  endtask

  task automatic test_redirect();
    for (int k = 0; k < 10; k++) begin
      if (k < 3)       apply(1'b1, 1'b0, 16'h0000, 1'b1);
      else if (k == 3) apply(1'b1, 1'b1, 16'h0040, 1'b1);
      else             apply(1'b0, 1'b0, 16'h0000, 1'b1);
      if ({o_valid, o_instr, o_pc, o_imemReq, o_imemAddr, o_halted} !== {e_valid, e_instr, e_pc, e_req, e_addr, e_halted}) begin
        n_err++;
        $display("FAIL redirect cyc %0d: got v=%b i=%h pc=%h req=%b a=%h h=%b, exp v=%b i=%h pc=%h req=%b a=%h h=%b", cyc,
                 o_valid, o_instr, o_pc, o_imemReq, o_imemAddr, o_halted, e_valid, e_instr, e_pc, e_req, e_addr, e_halted);
      end
      n_checks++;
      tick();
    end
  endtask

  task automatic test_halt();
    hlt_en   = 1'b1;
    hlt_addr = 16'h0003;
    for (int k = 0; k < 34; k++) begin
      if (k == 0)       apply(1'b0, 1'b1, 16'h0000, 1'b1);
      else if (k == 27) begin
        hlt_en = 1'b0;
        apply(1'b0, 1'b1, 16'h0010, 1'b1);
      end else          apply(($urandom % 4) == 0, 1'b0, 16'h0000, 1'b1);
      if ({o_valid, o_instr, o_pc, o_imemReq, o_imemAddr, o_halted} !== {e_valid, e_instr, e_pc, e_req, e_addr, e_halted}) begin
        n_err++;
        $display("FAIL halt cyc %0d: got v=%b i=%h pc=%h req=%b a=%h h=%b, exp v=%b i=%h pc=%h req=%b a=%h h=%b", cyc,
                 o_valid, o_instr, o_pc, o_imemReq, o_imemAddr, o_halted, e_valid, e_instr, e_pc, e_req, e_addr, e_halted);
      end
      n_checks++;
      tick();
    end
  endtask

  task automatic test_wrap();
    for (int k = 0; k < 7; k++) begin
      if (k == 0) apply(1'b0, 1'b1, 16'hFFFE, 1'b0);
      else        apply(1'b0, 1'b0, 16'h0000, 1'b1);
      if ({o_valid, o_instr, o_pc, o_imemReq, o_imemAddr, o_halted} !== {e_valid, e_instr, e_pc, e_req, e_addr, e_halted}) begin
        n_err++;
        $display("FAIL wrap cyc %0d: got v=%b i=%h pc=%h req=%b a=%h h=%b, exp v=%b i=%h pc=%h req=%b a=%h h=%b", cyc,
                 o_valid, o_instr, o_pc, o_imemReq, o_imemAddr, o_halted, e_valid, e_instr, e_pc, e_req, e_addr, e_halted);
      end
      n_checks++;
      tick();
    end
  endtask

  task automatic test_random();
    logic [15:0] tg;
    for (int k = 0; k < 400; k++) begin
      tg = 16'($urandom);
      apply(($urandom % 3) == 0, ($urandom % 16) == 0, tg, ($urandom % 2) == 1);
      if ({o_valid, o_instr, o_pc, o_imemReq, o_imemAddr, o_halted} !== {e_valid, e_instr, e_pc, e_req, e_addr, e_halted}) begin
        n_err++;
        $display("FAIL random cyc %0d: got v=%b i=%h pc=%h req=%b a=%h h=%b, exp v=%b i=%h pc=%h req=%b a=%h h=%b", cyc,
                 o_valid, o_instr, o_pc, o_imemReq, o_imemAddr, o_halted, e_valid, e_instr, e_pc, e_req, e_addr, e_halted);
      end
      n_checks++;
      tick();
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 4; k++) begin
      if (k == 0) apply(1'b0, 1'b1, 16'h0020, 1'b0);
      else        apply(1'b1, 1'b0, 16'h0000, 1'b1);
      tick();
    end
    if (o_valid !== 1'b1 || q_instr.size() != 2) begin
      n_err++;
      $display("FAIL rstmid_pre: got v=%b, exp v=1 with two buffered words", o_valid);
    end
    n_checks++;
    #2;
    i_nRst = 1'b0;
    #1;
    if ({o_valid, o_instr, o_imemReq, o_halted, o_pc} !== {1'b0, NOP, 1'b0, 1'b0, 16'h0000}) begin
      n_err++;
      $display("FAIL rstmid_async: got v=%b i=%h req=%b h=%b pc=%h, exp 0 %h 0 0 0000",
               o_valid, o_instr, o_imemReq, o_halted, o_pc, NOP);
    end
    n_checks++;
    model_reset();
    @(negedge i_clk);
    i_nRst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      apply(1'b0, 1'b0, 16'h0000, 1'b1);
      if ({o_valid, o_instr, o_pc, o_imemReq, o_imemAddr, o_halted} !== {e_valid, e_instr, e_pc, e_req, e_addr, e_halted}) begin
        n_err++;
        $display("FAIL rstmid cyc %0d: got v=%b i=%h pc=%h req=%b a=%h h=%b, exp v=%b i=%h pc=%h req=%b a=%h h=%b", cyc,
                 o_valid, o_instr, o_pc, o_imemReq, o_imemAddr, o_halted, e_valid, e_instr, e_pc, e_req, e_addr, e_halted);
      end
      n_checks++;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_halt();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

`default_nettype wire
